ysyx_25020037_wbu: RTL and testbench

//  Write-back stage of the multicycle core, directly downstream of the LSU.

---
 rtl/ysyx_25020037_wbu_pkg.sv | 45 ++++
 rtl/ysyx_25020037_wbu_if.sv | 30 +++
 rtl/ysyx_25020037_load_ext.sv | 26 ++
 rtl/ysyx_25020037_wbu.sv | 125 ++++++++++++
 tb/tb_ysyx_25020037_wbu.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared definitions for the write-back stage: widths, size encodings, trap causes and bus layouts.
package ysyx_25020037_wbu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RF_AW = 5;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    localparam logic [XLEN-1:0] CAUSE_LOAD_FAULT  = 32'd5;
    localparam logic [XLEN-1:0] CAUSE_STORE_FAULT = 32'd7;

    // addr + data + fault
    localparam int unsigned LU_TO_WU_BUS_WD = 2 * XLEN + 1;
    // rd + rf_we/is_load/is_store + size + unsigned + dnpc
    localparam int unsigned DU_TO_WU_BUS_WD = RF_AW + 3 + 3 + 1 + XLEN;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            fault;
    } lu_bus_t;

    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic             rf_we;
        logic             is_load;
        logic             is_store;
        logic [2:0]       size;
        logic             is_unsigned;
        logic [XLEN-1:0]  dnpc;
    } du_bus_t;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } wbu_state_e;

    function automatic logic [XLEN-1:0] fault_cause(input logic is_load);
        return is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
    endfunction

endpackage

// File: rtl/ysyx_25020037_wbu_if.sv
// LSU -> WBU result bus with valid/ready handshake; master is the LSU, slave is the WBU.
interface ysyx_25020037_wbu_if;
    import ysyx_25020037_wbu_pkg::*;

    logic             lsu_valid;
    logic             wbu_ready;
    logic [XLEN-1:0]  lu_addr;
    logic [XLEN-1:0]  lu_data;
    logic             access_fault;
    logic [RF_AW-1:0] du_rd;
    logic             du_rf_we;
    logic             du_is_load;
    logic             du_is_store;
    logic [2:0]       du_size;
    logic             du_unsigned;
    logic [XLEN-1:0]  du_dnpc;

    modport master (
        output lsu_valid, lu_addr, lu_data, access_fault, du_rd, du_rf_we,
               du_is_load, du_is_store, du_size, du_unsigned, du_dnpc,
        input  wbu_ready
    );

    modport slave (
        input  lsu_valid, lu_addr, lu_data, access_fault, du_rd, du_rf_we,
               du_is_load, du_is_store, du_size, du_unsigned, du_dnpc,
        output wbu_ready
    );

endinterface

// File: rtl/ysyx_25020037_load_ext.sv
// Load data extraction: shifts the aligned word by the byte offset, then sign/zero-extends.
module ysyx_25020037_load_ext
    import ysyx_25020037_wbu_pkg::*;
(
    input  logic [1:0]      addr_off,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] sh;

    assign sh = data >> {addr_off, 3'b000};

    // Misaligned halves are not checked; the shift simply pulls in zeros from the top.
    always_comb begin
        wdata = sh;
        case (size)
            SIZE_B:  wdata = {{(XLEN-8){~is_unsigned & sh[7]}}, sh[7:0]};
            SIZE_H:  wdata = {{(XLEN-16){~is_unsigned & sh[15]}}, sh[15:0]};
            default: wdata = sh;
        endcase
    end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back stage: retires one LSU result, writes the GPR file or raises a trap, hands next PC to IFU.
// Optional commit trace ports are added when YSYX_25020037_WBU_TRACE_EN is defined.
module ysyx_25020037_wbu
    import ysyx_25020037_wbu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ysyx_25020037_wbu_if.slave lsu,
    input  logic [XLEN-1:0]    mtvec,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               trap_valid,
    output logic [XLEN-1:0]    trap_cause,
    output logic [XLEN-1:0]    trap_tval,
    output logic               wbu_valid,
    input  logic               ifu_ready,
    output logic [XLEN-1:0]    next_pc
`ifdef YSYX_25020037_WBU_TRACE_EN
    ,
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc,
    output logic [RF_AW-1:0]   commit_rd
`endif
);

    wbu_state_e      state;
    lu_bus_t         lu_q;
    du_bus_t         du_q;
    logic [XLEN-1:0] mtvec_q;
    logic            wbu_ready_q;
    logic [XLEN-1:0] ld_wdata;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            unused_is_store;

    assign lsu.wbu_ready   = wbu_ready_q;
    assign wb_data         = du_q.is_load ? ld_wdata : lu_q.data;
    assign wb_we           = du_q.rf_we && (du_q.rd != '0) && !lu_q.fault;
    // Cause only distinguishes load vs. everything else.
    assign unused_is_store = du_q.is_store;

    ysyx_25020037_load_ext u_load_ext (
        .addr_off    (lu_q.addr[1:0]),
        .data        (lu_q.data),
        .size        (du_q.size),
        .is_unsigned (du_q.is_unsigned),
        .wdata       (ld_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            wbu_ready_q  <= 1'b1;
            lu_q         <= '0;
            du_q         <= '0;
            mtvec_q      <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            trap_valid   <= 1'b0;
            trap_cause   <= '0;
            trap_tval    <= '0;
            wbu_valid    <= 1'b0;
            next_pc      <= '0;
`ifdef YSYX_25020037_WBU_TRACE_EN
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_rd    <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (lsu.lsu_valid && wbu_ready_q) begin
                        lu_q        <= '{addr: lsu.lu_addr, data: lsu.lu_data,
                                         fault: lsu.access_fault};
                        du_q        <= '{rd: lsu.du_rd, rf_we: lsu.du_rf_we,
                                         is_load: lsu.du_is_load, is_store: lsu.du_is_store,
                                         size: lsu.du_size, is_unsigned: lsu.du_unsigned,
                                         dnpc: lsu.du_dnpc};
                        mtvec_q     <= mtvec;
                        wbu_ready_q <= 1'b0;
                        state       <= StWrite;
                    end
                end
                StWrite: begin
                    rf_we    <= wb_we;
                    rf_waddr <= du_q.rd;
                    rf_wdata <= wb_data;
                    if (lu_q.fault) begin
                        trap_valid <= 1'b1;
                        trap_cause <= fault_cause(du_q.is_load);
                        trap_tval  <= lu_q.addr;
                        next_pc    <= mtvec_q;
                    end else begin
                        next_pc    <= du_q.dnpc;
                    end
`ifdef YSYX_25020037_WBU_TRACE_EN
                    commit_valid <= 1'b1;
                    commit_pc    <= du_q.dnpc;
                    commit_rd    <= wb_we ? du_q.rd : '0;
`endif
                    state <= StDone;
                end
                StDone: begin
                    rf_we      <= 1'b0;
                    trap_valid <= 1'b0;
`ifdef YSYX_25020037_WBU_TRACE_EN
                    commit_valid <= 1'b0;
`endif
                    // wbu_valid rises on the first DONE edge, so the IFU handshake lands later.
                    if (wbu_valid && ifu_ready) begin
                        wbu_valid   <= 1'b0;
                        wbu_ready_q <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        wbu_valid   <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Self-checking bench for ysyx_25020037_wbu: scoreboard of expected write-back results per instruction.
module tb_ysyx_25020037_wbu;
    import ysyx_25020037_wbu_pkg::*;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        trap;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mtvec;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        wbu_valid;
    logic        ifu_ready;
    logic [31:0] next_pc;
`ifdef YSYX_25020037_WBU_TRACE_EN
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  commit_rd;
`endif

    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];

    ysyx_25020037_wbu_if bus ();

    ysyx_25020037_wbu u_dut (
        .clk        (clk),
        .rst        (rst),
        .lsu        (bus),
        .mtvec      (mtvec),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_tval  (trap_tval),
        .wbu_valid  (wbu_valid),
        .ifu_ready  (ifu_ready),
`ifdef YSYX_25020037_WBU_TRACE_EN
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_rd    (commit_rd),
`endif
        .next_pc    (next_pc)
    );

    always #5 clk = ~clk;

    // Byte-lane model of load extraction.
    function automatic logic [31:0] model_wdata(input logic [31:0] addr, input logic [31:0] data,
                                                input logic ld, input logic [2:0] size,
                                                input logic uns);
        logic [7:0] b [4];
        logic [7:0] s [4];
        int off;
        int j;
        if (!ld) return data;
        for (int i = 0; i < 4; i++) b[i] = data[8*i +: 8];
        off = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            j = off + i;
            s[i] = (j < 4) ? b[j] : 8'h00;
        end
        if (size == 3'b001) return uns ? {24'h0, s[0]} : {{24{s[0][7]}}, s[0]};
        if (size == 3'b010) return uns ? {16'h0, s[1], s[0]} : {{16{s[1][7]}}, s[1], s[0]};
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic drive_op(input logic [31:0] addr, input logic [31:0] data, input logic fault,
                            input logic [4:0] rd, input logic we, input logic ld, input logic st,
                            input logic [2:0] size, input logic uns, input logic [31:0] dnpc);
        bus.lu_addr      = addr;
        bus.lu_data      = data;
        bus.access_fault = fault;
        bus.du_rd        = rd;
        bus.du_rf_we     = we;
        bus.du_is_load   = ld;
        bus.du_is_store  = st;
        bus.du_size      = size;
        bus.du_unsigned  = uns;
        bus.du_dnpc      = dnpc;
    endtask

    // Runs one transaction from a negedge; tim = {idle again @N+3, we|trap @N+2, valid @N+2, valid @N+1}.
    task automatic run_op(output exp_t obs, output logic [3:0] tim, output logic [31:0] cause,
                          output logic [31:0] tval);
        int n = 0;
        bus.lsu_valid = 1'b1;
        ifu_ready     = 1'b1;
        while (bus.wbu_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        @(posedge clk); #1;
        obs    = '{rf_we, rf_waddr, rf_wdata, trap_valid, next_pc};
        cause  = trap_cause;
        tval   = trap_tval;
        tim[0] = wbu_valid;
        @(posedge clk); #1;
        tim[1] = wbu_valid;
        tim[2] = rf_we | trap_valid;
        @(posedge clk); #1;
        tim[3] = !wbu_valid && bus.wbu_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nvec++;
        if ({bus.wbu_ready, rf_we, trap_valid, wbu_valid, rf_waddr, rf_wdata, trap_cause,
             trap_tval, next_pc} !== {1'b1, 3'b000, 5'd0, 128'd0}) begin
            nerr++;
            $display("FAIL reset_held: ready=%b we=%b trap=%b valid=%b npc=%h, required 1 0 0 0 0",
                     bus.wbu_ready, rf_we, trap_valid, wbu_valid, next_pc);
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({bus.wbu_ready, rf_we, trap_valid, wbu_valid, next_pc} !== {1'b1, 3'b000, 32'd0}) begin
            nerr++;
            $display("FAIL reset_released: ready=%b we=%b trap=%b valid=%b npc=%h, required 1 0 0 0 0",
                     bus.wbu_ready, rf_we, trap_valid, wbu_valid, next_pc);
        end
    endtask

    task automatic test_loads();
        logic [31:0] ta [8];
        logic [31:0] td [8];
        logic [2:0]  tsz [8];
        logic        tu [8];
        exp_t e, obs;
        logic [3:0] tim;
        logic [31:0] c, t;
        ta  = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0000, 32'h8000_0000,
                32'h8000_0001, 32'h8000_0003, 32'h8000_0001, 32'h8000_0001};
        td  = '{32'h8000_0000, 32'hBEEF_1234, 32'hDEAD_BEEF, 32'h0000_8765,
                32'h1234_5678, 32'h9ABC_DEF0, 32'h1122_3344, 32'h7F00_FF00};
        tsz = '{SIZE_B, SIZE_H, SIZE_W, SIZE_H, SIZE_B, SIZE_H, 3'b011, SIZE_B};
        tu  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            e = '{1'b1, 5'(5 + i), model_wdata(ta[i], td[i], 1'b1, tsz[i], tu[i]), 1'b0,
                  32'h8000_0004 + 32'(4 * i)};
            sb.push_back(e);
            drive_op(ta[i], td[i], 1'b0, 5'(5 + i), 1'b1, 1'b1, 1'b0, tsz[i], tu[i],
                     32'h8000_0004 + 32'(4 * i));
            run_op(obs, tim, c, t);
            e = sb.pop_front();
            nvec++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL load[%0d]: got we=%b rd=%0d wdata=%h trap=%b npc=%h, required we=%b rd=%0d wdata=%h trap=%b npc=%h",
                         i, obs.we, obs.waddr, obs.wdata, obs.trap, obs.npc,
                         e.we, e.waddr, e.wdata, e.trap, e.npc);
            end
            nvec++;
            if (tim !== 4'b1010) begin
                nerr++;
                $display("FAIL load[%0d]_timing: got %b, required 1010", i, tim);
            end
        end
    endtask

    task automatic test_non_load();
        exp_t e, obs;
        logic [3:0] tim;
        logic [31:0] c, t;
        // ADDI to x0
        sb.push_back('{1'b0, 5'd0, 32'h0000_1234, 1'b0, 32'h8000_0104});
        drive_op(32'h1234, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h8000_0104);
        run_op(obs, tim, c, t);
        e = sb.pop_front();
        nvec++;
        if (obs !== e || tim !== 4'b1010) begin
            nerr++;
            $display("FAIL addi_x0: got we=%b wdata=%h npc=%h tim=%b, required we=0 wdata=%h npc=%h tim=1010",
                     obs.we, obs.wdata, obs.npc, tim, e.wdata, e.npc);
        end
        // ALU result to x3
        sb.push_back('{1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, 32'h8000_0108});
        drive_op(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b1,
                 32'h8000_0108);
        run_op(obs, tim, c, t);
        e = sb.pop_front();
        nvec++;
        if (obs !== e) begin
            nerr++;
            $display("FAIL alu_x3: got we=%b rd=%0d wdata=%h npc=%h, required we=1 rd=3 wdata=%h npc=%h",
                     obs.we, obs.waddr, obs.wdata, obs.npc, e.wdata, e.npc);
        end
        // Store, no fault
        sb.push_back('{1'b0, 5'd9, 32'h8000_2002, 1'b0, 32'h8000_010C});
        drive_op(32'h8000_2002, 32'h8000_2002, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, SIZE_H, 1'b0,
                 32'h8000_010C);
        run_op(obs, tim, c, t);
        e = sb.pop_front();
        nvec++;
        if (obs !== e) begin
            nerr++;
            $display("FAIL store_ok: got we=%b rd=%0d wdata=%h trap=%b npc=%h, required we=0 rd=9 wdata=%h trap=0 npc=%h",
                     obs.we, obs.waddr, obs.wdata, obs.trap, obs.npc, e.wdata, e.npc);
        end
    endtask

    task automatic test_fault();
        exp_t e, obs;
        logic [3:0] tim;
        logic [31:0] c, t;
        sb.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0100});
        drive_op(32'hA000_0000, 32'hA000_0000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, SIZE_W, 1'b0,
                 32'h8000_0044);
        run_op(obs, tim, c, t);
        e = sb.pop_front();
        nvec++;
        if ({obs.we, obs.trap, obs.npc, tim} !== {e.we, e.trap, e.npc, 4'b1010}) begin
            nerr++;
            $display("FAIL store_fault: got we=%b trap=%b npc=%h tim=%b, required we=0 trap=1 npc=%h tim=1010",
                     obs.we, obs.trap, obs.npc, tim, e.npc);
        end
        nvec++;
        if ({c, t} !== {32'd7, 32'hA000_0000}) begin
            nerr++;
            $display("FAIL store_fault_cause: got cause=%0d tval=%h, required cause=7 tval=a0000000",
                     c, t);
        end
        // Load fault must not write even with rf_we and rd!=0
        sb.push_back('{1'b0, 5'd5, 32'h0, 1'b1, 32'h8000_0100});
        drive_op(32'h0000_0010, 32'h5555_5555, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, SIZE_W, 1'b0,
                 32'h8000_0048);
        run_op(obs, tim, c, t);
        e = sb.pop_front();
        nvec++;
        if ({obs.we, obs.trap, obs.npc} !== {e.we, e.trap, e.npc}) begin
            nerr++;
            $display("FAIL load_fault: got we=%b trap=%b npc=%h, required we=0 trap=1 npc=%h",
                     obs.we, obs.trap, obs.npc, e.npc);
        end
        nvec++;
        if ({c, t} !== {32'd5, 32'h0000_0010}) begin
            nerr++;
            $display("FAIL load_fault_cause: got cause=%0d tval=%h, required cause=5 tval=00000010",
                     c, t);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        sb.push_back('{1'b1, 5'd4, 32'h55, 1'b0, 32'h8000_0200});
        drive_op(32'h55, 32'h55, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h8000_0200);
        bus.lsu_valid = 1'b1;
        ifu_ready     = 1'b0;
        @(posedge clk); #1;
        // LSU presents a second op while the first is in flight
        drive_op(32'h66, 32'h66, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h8000_0300);
        @(posedge clk); #1;
        e = sb.pop_front();
        nvec++;
        if ({rf_we, rf_waddr, rf_wdata, trap_valid, next_pc} !== e) begin
            nerr++;
            $display("FAIL stall_first_write: got we=%b rd=%0d wdata=%h npc=%h, required we=1 rd=4 wdata=00000055 npc=80000200",
                     rf_we, rf_waddr, rf_wdata, next_pc);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            nvec++;
            if ({wbu_valid, bus.wbu_ready, rf_we, rf_waddr, next_pc} !==
                {1'b1, 1'b0, 1'b0, 5'd4, 32'h8000_0200}) begin
                nerr++;
                $display("FAIL stall_hold[%0d]: got valid=%b ready=%b we=%b rd=%0d npc=%h, required 1 0 0 4 80000200",
                         k, wbu_valid, bus.wbu_ready, rf_we, rf_waddr, next_pc);
            end
            @(posedge clk); #1;
        end
        bus.lsu_valid = 1'b0;
        ifu_ready     = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if ({wbu_valid, bus.wbu_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL stall_release: got valid=%b ready=%b, required 0 1", wbu_valid,
                     bus.wbu_ready);
        end
        ifu_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e, obs;
        logic [3:0] tim;
        logic [31:0] c, t;
        drive_op(32'h8000_0010, 32'h1111_1111, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, SIZE_W, 1'b0,
                 32'h8000_0400);
        bus.lsu_valid = 1'b1;
        ifu_ready     = 1'b1;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({bus.wbu_ready, rf_we, trap_valid, wbu_valid} !== 4'b1000) begin
            nerr++;
            $display("FAIL arst_in_write: got ready=%b we=%b trap=%b valid=%b, required 1 0 0 0",
                     bus.wbu_ready, rf_we, trap_valid, wbu_valid);
        end
        @(posedge clk); #1;
        nvec++;
        if ({rf_we, trap_valid, wbu_valid, rf_waddr, next_pc} !== 40'd0) begin
            nerr++;
            $display("FAIL arst_dropped: got we=%b trap=%b valid=%b rd=%0d npc=%h, required all 0",
                     rf_we, trap_valid, wbu_valid, rf_waddr, next_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset while the write strobe is high
        drive_op(32'h77, 32'h77, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h8000_0500);
        bus.lsu_valid = 1'b1;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if ({rf_we, rf_waddr} !== {1'b1, 5'd14}) begin
            nerr++;
            $display("FAIL arst_pre_write: got we=%b rd=%0d, required we=1 rd=14", rf_we, rf_waddr);
        end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if ({rf_we, rf_waddr, rf_wdata, next_pc, bus.wbu_ready} !== {1'b0, 5'd0, 64'd0, 1'b1}) begin
            nerr++;
            $display("FAIL arst_strobe: got we=%b rd=%0d wdata=%h npc=%h ready=%b, required 0 0 0 0 1",
                     rf_we, rf_waddr, rf_wdata, next_pc, bus.wbu_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb.push_back('{1'b1, 5'd15, 32'hFFFF_FFA5, 1'b0, 32'h8000_0600});
        drive_op(32'h8000_0001, 32'h0000_A500, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, SIZE_B, 1'b0,
                 32'h8000_0600);
        run_op(obs, tim, c, t);
        e = sb.pop_front();
        nvec++;
        if (obs !== e || tim !== 4'b1010) begin
            nerr++;
            $display("FAIL arst_recover: got we=%b rd=%0d wdata=%h npc=%h tim=%b, required we=1 rd=15 wdata=ffffffa5 npc=80000600 tim=1010",
                     obs.we, obs.waddr, obs.wdata, obs.npc, tim);
        end
    endtask

    initial begin
        mtvec = 32'h8000_0100;
        ifu_ready = 1'b0;
        bus.lsu_valid = 1'b0;
        drive_op(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, SIZE_W, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        test_reset();
        test_loads();
        test_non_load();
        test_fault();
        test_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
